// File: rtl/trace_dump_controller.sv
// trace_dump_controller: records datapath vectors into an external dual-port
// trace buffer and reads them back oldest-first through a valid/ready stream.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start_tracing            pulse: clear pointers and begin capturing
//   stop_tracing             pulse: end capturing
//   valid_in                 vector to record this cycle (while capturing)
//   dump_start               pulse: read back captured contents
//   tracing                  high while capturing
//   wr_en, wr_addr           memory port A (write)
//   rd_addr, mem_rd_data     memory port B (read, RAM_LATENCY cycles)
//   dump_data, dump_valid    readout stream payload / valid
//   dump_ready               readout stream ready
//   dump_last                remaining count is one (final entry)
//   dump_done                pulse after the dump completes
//   busy                     controller not idle
module trace_dump_controller #(
   parameter int unsigned N           = 8,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned TB_SIZE     = 64,
   parameter int unsigned RAM_LATENCY = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start_tracing,
   input  logic                          stop_tracing,
   input  logic                          valid_in,
   input  logic                          dump_start,
   output logic                          tracing,
   output logic                          wr_en,
   output logic [$clog2(TB_SIZE)-1:0]    wr_addr,
   output logic [$clog2(TB_SIZE)-1:0]    rd_addr,
   input  logic [N*DATA_WIDTH-1:0]       mem_rd_data,
   output logic [N*DATA_WIDTH-1:0]       dump_data,
   output logic                          dump_valid,
   input  logic                          dump_ready,
   output logic                          dump_last,
   output logic                          dump_done,
   output logic                          busy
);

   localparam int unsigned AW = $clog2(TB_SIZE);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned LW = $clog2(RAM_LATENCY + 1);
   localparam int unsigned VW = N * DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      TRACE,
      RD_ISSUE,
      RD_WAIT,
      OUT
   } state_t;

   state_t        state;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wrapped;
   logic [CW-1:0] remaining;
   logic [LW-1:0] wait_cnt;
   logic [CW-1:0] dump_cnt;
   logic [AW-1:0] dump_base;

   // Once wrapped, the oldest entry sits at wr_ptr and the buffer is full.
   assign dump_cnt  = wrapped ? CW'(TB_SIZE) : {1'b0, wr_ptr};
   assign dump_base = wrapped ? wr_ptr : '0;

   // Write port follows valid_in in the same cycle so no vector is delayed.
   assign wr_en     = (state == TRACE) && valid_in;
   assign wr_addr   = wr_ptr;
   assign rd_addr   = rd_ptr;
   assign tracing   = (state == TRACE);
   assign busy      = (state != IDLE);
   assign dump_last = (remaining == CW'(1));

   // Controller state, pointers and readout registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         wrapped    <= 1'b0;
         remaining  <= '0;
         wait_cnt   <= '0;
         dump_data  <= '0;
         dump_valid <= 1'b0;
         dump_done  <= 1'b0;
      end else begin
         dump_done <= 1'b0;
         case (state)
            IDLE: begin
               // dump_start wins over start_tracing
               if (dump_start) begin
                  if (dump_cnt == '0) begin
                     dump_done <= 1'b1;
                  end else begin
                     rd_ptr    <= dump_base;
                     remaining <= dump_cnt;
                     state     <= RD_ISSUE;
                  end
               end else if (start_tracing) begin
                  wr_ptr  <= '0;
                  wrapped <= 1'b0;
                  state   <= TRACE;
               end
            end
            TRACE: begin
               if (valid_in) begin
                  wr_ptr <= wr_ptr + AW'(1);
                  if (wr_ptr == AW'(TB_SIZE - 1)) wrapped <= 1'b1;
               end
               if (stop_tracing) state <= IDLE;
            end
            RD_ISSUE: begin
               wait_cnt <= LW'(RAM_LATENCY);
               state    <= RD_WAIT;
            end
            RD_WAIT: begin
               if (wait_cnt == LW'(1)) begin
                  dump_data  <= VW'(mem_rd_data);
                  dump_valid <= 1'b1;
                  state      <= OUT;
               end else begin
                  wait_cnt <= wait_cnt - LW'(1);
               end
            end
            OUT: begin
               if (dump_ready) begin
                  dump_valid <= 1'b0;
                  rd_ptr     <= rd_ptr + AW'(1);
                  remaining  <= remaining - CW'(1);
                  if (remaining == CW'(1)) begin
                     dump_done <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     state <= RD_ISSUE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trace_dump_controller.sv
// tb_trace_dump_controller: directed scenarios against a small synchronous
// dual-port memory model (TB_SIZE=4, RAM_LATENCY=1, 2 lanes x 8 bits).
module tb_trace_dump_controller;

   localparam int unsigned N   = 2;
   localparam int unsigned DW  = 8;
   localparam int unsigned TBS = 4;
   localparam int unsigned LAT = 1;
   localparam int unsigned VW  = N * DW;
   localparam int unsigned AW  = $clog2(TBS);

   logic          clk = 1'b0;
   logic          rst;
   logic          start_tracing, stop_tracing, valid_in, dump_start, dump_ready;
   logic          tracing, wr_en, dump_valid, dump_last, dump_done, busy;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [VW-1:0] mem_rd_data, dump_data, wdata;
   logic [VW-1:0] mem [TBS];
   logic [VW-1:0] exp_q [$];

   int n_cmp = 0;
   int n_bad = 0;

   trace_dump_controller #(.N(N), .DATA_WIDTH(DW), .TB_SIZE(TBS), .RAM_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .start_tracing(start_tracing), .stop_tracing(stop_tracing),
      .valid_in(valid_in), .dump_start(dump_start),
      .tracing(tracing), .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
      .mem_rd_data(mem_rd_data), .dump_data(dump_data), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_last(dump_last), .dump_done(dump_done),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Synchronous memory: one cycle read latency, not touched by reset.
   always @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wdata;
      mem_rd_data <= mem[rd_addr];
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_trace(input int n, input logic [VW-1:0] base, input bit stop_with_last);
      start_tracing = 1'b1;
      cyc();
      start_tracing = 1'b0;
      n_cmp++;
      if (tracing !== 1'b1) begin
         n_bad++;
         $display("FAIL trace_enter tracing=%b want 1", tracing);
      end
      for (int i = 0; i < n; i++) begin
         valid_in     = 1'b1;
         wdata        = base + VW'(i);
         stop_tracing = stop_with_last && (i == n - 1);
         #1;
         n_cmp++;
         if ({wr_en, wr_addr} !== {1'b1, AW'(i)}) begin
            n_bad++;
            $display("FAIL trace_write[%0d] wr_en=%b wr_addr=%0d want 1/%0d", i, wr_en, wr_addr, i % TBS);
         end
         cyc();
      end
      valid_in     = 1'b0;
      stop_tracing = 1'b0;
      if (!stop_with_last) begin
         stop_tracing = 1'b1;
         cyc();
         stop_tracing = 1'b0;
      end
      n_cmp++;
      if ({tracing, busy} !== 2'b00) begin
         n_bad++;
         $display("FAIL trace_exit tracing=%b busy=%b want 0/0", tracing, busy);
      end
   endtask

   // Dump of n entries expected in exp_q; optional stall, first-address check,
   // coincident start_tracing and control noise while the dump runs.
   task automatic run_dump(input int n, input int stall_idx, input int stall_cycles,
                           input int first_addr, input bit also_start, input bit noise);
      int k      = 0;
      int stall  = 0;
      int budget = 200;
      bit hs;
      dump_ready    = 1'b1;
      dump_start    = 1'b1;
      start_tracing = also_start;
      cyc();
      dump_start    = 1'b0;
      start_tracing = 1'b0;
      if (first_addr >= 0) begin
         n_cmp++;
         if (rd_addr !== AW'(first_addr)) begin
            n_bad++;
            $display("FAIL dump_first_addr rd_addr=%0d want %0d", rd_addr, first_addr);
         end
      end
      while (k < n && budget > 0) begin
         start_tracing = noise;
         stop_tracing  = noise;
         dump_start    = noise;
         dump_ready    = 1'b1;
         if (dump_valid === 1'b1) begin
            n_cmp++;
            if (dump_data !== exp_q[k] || dump_last !== (k == n - 1)) begin
               n_bad++;
               $display("FAIL dump_entry[%0d] data=%0d last=%b want %0d/%b",
                        k, dump_data, dump_last, exp_q[k], (k == n - 1));
            end
            if (k == stall_idx && stall < stall_cycles) begin
               dump_ready = 1'b0;
               stall++;
            end
         end
         hs = (dump_valid === 1'b1) && dump_ready;
         cyc();
         if (hs) k++;
         budget--;
      end
      start_tracing = 1'b0;
      stop_tracing  = 1'b0;
      dump_start    = 1'b0;
      dump_ready    = 1'b1;
      n_cmp++;
      if (k != n) begin
         n_bad++;
         $display("FAIL dump_timeout delivered=%0d want %0d", k, n);
      end
      n_cmp++;
      if ({dump_done, dump_valid, busy} !== 3'b100) begin
         n_bad++;
         $display("FAIL dump_done_pulse done/valid/busy=%b%b%b want 100", dump_done, dump_valid, busy);
      end
      cyc();
      n_cmp++;
      if ({dump_done, dump_valid, busy, tracing} !== 4'b0000) begin
         n_bad++;
         $display("FAIL dump_after done/valid/busy/tracing=%b%b%b%b want 0000",
                  dump_done, dump_valid, busy, tracing);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc();
      cyc();
      n_cmp++;
      if ({tracing, wr_en, dump_valid, dump_last, dump_done, busy, wr_addr, rd_addr, dump_data} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs t/we/v/l/d/b=%b%b%b%b%b%b wa=%0d ra=%0d data=%0h want all 0",
                  tracing, wr_en, dump_valid, dump_last, dump_done, busy, wr_addr, rd_addr, dump_data);
      end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_nonwrapped();
      do_trace(3, VW'(10), 1'b0);
      valid_in     = 1'b1;
      stop_tracing = 1'b1;
      #1;
      n_cmp++;
      if (wr_en !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_wr_en wr_en=%b want 0", wr_en);
      end
      cyc();
      valid_in     = 1'b0;
      stop_tracing = 1'b0;
      n_cmp++;
      if ({busy, wr_addr} !== {1'b0, AW'(3)}) begin
         n_bad++;
         $display("FAIL idle_ignore busy=%b wr_addr=%0d want 0/3", busy, wr_addr);
      end
      exp_q = '{VW'(10), VW'(11), VW'(12)};
      run_dump(3, -1, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_wrap();
      do_trace(6, VW'(1), 1'b0);
      exp_q = '{VW'(3), VW'(4), VW'(5), VW'(6)};
      run_dump(4, -1, 0, 2, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      // Repeat dump of the wrapped contents, stalling the second entry.
      exp_q = '{VW'(3), VW'(4), VW'(5), VW'(6)};
      run_dump(4, 1, 5, 2, 1'b0, 1'b0);
   endtask

   task automatic test_empty();
      do_trace(0, VW'(0), 1'b0);
      exp_q = {};
      run_dump(0, -1, 0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_simultaneous();
      do_trace(2, VW'(7), 1'b1);
      exp_q = '{VW'(7), VW'(8)};
      run_dump(2, -1, 0, 0, 1'b1, 1'b1);
      n_cmp++;
      if (wr_addr !== AW'(2)) begin
         n_bad++;
         $display("FAIL simul_ptr wr_addr=%0d want 2", wr_addr);
      end
      exp_q = '{VW'(7), VW'(8)};
      run_dump(2, -1, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_dump();
      int budget = 50;
      do_trace(3, VW'(20), 1'b0);
      dump_ready = 1'b0;
      dump_start = 1'b1;
      cyc();
      dump_start = 1'b0;
      while (dump_valid !== 1'b1 && budget > 0) begin
         cyc();
         budget--;
      end
      n_cmp++;
      if (dump_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_reach_out dump_valid=%b want 1", dump_valid);
      end
      rst = 1'b1;
      cyc();
      rst        = 1'b0;
      dump_ready = 1'b1;
      n_cmp++;
      if ({tracing, wr_en, dump_valid, dump_last, dump_done, busy, wr_addr, rd_addr, dump_data} !== '0) begin
         n_bad++;
         $display("FAIL midrst_outputs t/we/v/l/d/b=%b%b%b%b%b%b wa=%0d ra=%0d data=%0h want all 0",
                  tracing, wr_en, dump_valid, dump_last, dump_done, busy, wr_addr, rd_addr, dump_data);
      end
      exp_q = {};
      run_dump(0, -1, 0, -1, 1'b0, 1'b0);
   endtask

   initial begin
      rst           = 1'b1;
      start_tracing = 1'b0;
      stop_tracing  = 1'b0;
      valid_in      = 1'b0;
      dump_start    = 1'b0;
      dump_ready    = 1'b1;
      wdata         = '0;
      test_reset();
      test_nonwrapped();
      test_wrap();
      test_backpressure();
      test_empty();
      test_simultaneous();
      test_reset_mid_dump();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/trace_dump_controller.md
TRACE_DUMP_CONTROLLER -- requirements
Module: trace_dump_controller

Interface
REQ-001 The block SHALL have parameters: N, default 8, vector lanes; DATA_WIDTH, default 32, bits per lane; TB_SIZE, default 64, buffer entries (power of two); RAM_LATENCY, default 1, memory read latency in cycles (>=1).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Port list (name, direction, width, meaning):
REQ-003 clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start_tracing  input  1  one-cycle pulse; begins a new trace capture.
REQ-006 stop_tracing  input  1  one-cycle pulse; ends the capture.
REQ-007 valid_in  input  1  the datapath has a vector to record this cycle.
REQ-008 dump_start  input  1  one-cycle pulse; requests readout of the captured contents.
REQ-009 tracing  output  1  high while capturing.
REQ-010 wr_en  output  1  memory port-A write enable.
REQ-011 wr_addr  output  $clog2(TB_SIZE)  memory port-A address.
REQ-012 rd_addr  output  $clog2(TB_SIZE)  memory port-B address.
REQ-013 mem_rd_data  input  N*DATA_WIDTH  memory port-B data, valid RAM_LATENCY cycles after rd_addr is presented.
REQ-014 dump_data  output  N*DATA_WIDTH  registered readout vector.
REQ-015 dump_valid  output  1  dump_data holds an entry.
REQ-016 dump_ready  input  1  the consumer accepts dump_data.
REQ-017 dump_last  output  1  the current dump_data is the final entry of the dump.
REQ-018 dump_done  output  1  one-cycle pulse after the dump completes.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have five states: IDLE, TRACE, RD_ISSUE, RD_WAIT, OUT.
REQ-021 In IDLE, dump_start SHALL take priority over start_tracing when both are asserted in the same cycle.
REQ-022 In IDLE, start_tracing SHALL clear wr_ptr and the wrapped flag and move the FSM to TRACE; tracing SHALL be high from the next cycle.
REQ-023 In TRACE, wr_en SHALL equal valid_in combinationally and wr_addr SHALL equal wr_ptr.
REQ-024 Each cycle valid_in is high in TRACE, wr_ptr SHALL increment modulo TB_SIZE.
REQ-025 When wr_ptr wraps from TB_SIZE-1 to 0, wrapped SHALL be set and SHALL remain set until the next start_tracing.
REQ-026 Outside TRACE, wr_en SHALL be 0.
REQ-027 stop_tracing in TRACE SHALL return the FSM to IDLE; a valid_in asserted in the same cycle SHALL still be written.
REQ-028 start_tracing while in TRACE SHALL be ignored.
REQ-029 stop_tracing outside TRACE SHALL be ignored.
REQ-030 The dump count SHALL be TB_SIZE if wrapped, else wr_ptr.
REQ-031 The dump start address SHALL be wr_ptr if wrapped, else 0, so entries are delivered oldest first.
REQ-032 dump_start in IDLE with a count of 0 SHALL pulse dump_done on the next cycle and stay in IDLE, with dump_valid never asserted.
REQ-033 dump_start in IDLE with a nonzero count SHALL load rd_ptr and a remaining-count register, then go to RD_ISSUE.
REQ-034 RD_ISSUE SHALL drive rd_addr=rd_ptr for one cycle, then go to RD_WAIT.
REQ-035 RD_WAIT SHALL last RAM_LATENCY cycles, then register mem_rd_data into dump_data and go to OUT.
REQ-036 In OUT, dump_valid SHALL be 1, and dump_data and dump_last SHALL be held stable until dump_ready is high.
REQ-037 dump_last SHALL be 1 exactly when the remaining count is 1.
REQ-038 A handshake (dump_valid & dump_ready) SHALL increment rd_ptr modulo TB_SIZE and decrement the remaining count.
REQ-039 After a handshake, the FSM SHALL go to RD_ISSUE if entries remain; otherwise it SHALL go to IDLE and pulse dump_done in the following cycle.
REQ-040 start_tracing, stop_tracing and dump_start SHALL be ignored while a dump is in progress.
REQ-041 Captured contents and wr_ptr/wrapped SHALL be preserved across a dump, so a repeat dump returns identical data.

Reset
REQ-042 On rst=1 at a clock edge, the FSM SHALL go to IDLE from any state, including mid-dump and mid-trace.
REQ-043 On reset, wr_ptr, rd_ptr, the remaining count and wrapped SHALL be 0.
REQ-044 On reset, tracing, wr_en, dump_valid, dump_last, dump_done and busy SHALL be 0, and dump_data SHALL be all zeros.
REQ-045 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-046 Non-wrapped dump (TB_SIZE=4, RAM_LATENCY=1): trace 3 vectors (values 10, 11, 12), stop, dump with dump_ready=1 -> dump_data 10, 11, 12 with dump_last on 12, dump_done one cycle after the last handshake.
REQ-047 Wrap-around: trace 6 vectors (1 to 6) into TB_SIZE=4, then dump -> data 3, 4, 5, 6; count 4; first rd_addr=2.
REQ-048 Backpressure: hold dump_ready=0 for 5 cycles on the second entry -> dump_valid stays high and dump_data stays stable; no entry is skipped or duplicated.
REQ-049 Empty dump: start, then immediately stop with no valid_in, then dump_start -> dump_done pulses on the next cycle and dump_valid stays 0.
REQ-050 Simultaneous events: stop_tracing coincident with valid_in is written; dump_start and start_tracing together in IDLE -> a dump occurs and the trace pointers are unchanged.
REQ-051 Reset mid-dump: assert rst while in OUT -> all outputs are 0 the next cycle; a following dump_start replays a zero count and only dump_done pulses.
